sha512_round_ctrl: RTL and testbench

//  Iterative sequencer for the SHA-512 compression datapath, which replaces the one-shot combinational hash.

---
 rtl/sha512_round_ctrl.sv | 127 ++++++++++++
 tb/tb_sha512_round_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha512_round_ctrl.sv
// sha512_round_ctrl: iterative SHA-512 block sequencer and message-schedule generator.
// Defining SHA512_BLK_CNT_EN adds the saturating blk_count output.
module sha512_round_ctrl #(
    parameter int ROUNDS = 80,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          blk_valid,
    output logic          blk_ready,
    input  logic [1023:0] blk_data,
    input  logic          blk_first,
    input  logic          blk_last,
    output logic          init_h,
    output logic          load_wv,
    output logic          round_en,
    output logic [6:0]    round_idx,
    output logic [63:0]   w_t,
    output logic          update_h,
    output logic          digest_valid,
`ifdef SHA512_BLK_CNT_EN
    output logic          busy,
    output logic [CNT_W-1:0] blk_count
`else
    output logic          busy
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    state_t      state, nxt;
    logic [63:0] sched [16];
    logic [63:0] w_new;
    logic        first_q, last_q;
    logic        accept;

    function automatic logic [63:0] sig0(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    // sched[0] is always the current W_t, so the word 16 rounds ahead uses taps 14, 9, 1, 0
    assign w_new  = sig1(sched[14]) + sched[9] + sig0(sched[1]) + sched[0];
    assign accept = blk_valid && blk_ready;
    assign busy   = state != IDLE;
    assign w_t    = round_en ? sched[0] : 64'd0;

    // State register; blk_ready is registered and only high while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            blk_ready <= 1'b1;
        end else begin
            state     <= nxt;
            blk_ready <= nxt == IDLE;
        end
    end

    // Next-state decode and per-state datapath strobes
    always_comb begin
        nxt          = state;
        init_h       = 1'b0;
        load_wv      = 1'b0;
        round_en     = 1'b0;
        update_h     = 1'b0;
        digest_valid = 1'b0;
        case (state)
            IDLE:    nxt = accept ? LOAD : IDLE;
            LOAD: begin
                load_wv = 1'b1;
                init_h  = first_q;
                nxt     = ROUND;
            end
            ROUND: begin
                round_en = 1'b1;
                nxt      = round_idx == LAST_T ? UPDATE : ROUND;
            end
            UPDATE: begin
                update_h = 1'b1;
                nxt      = last_q ? DONE : IDLE;
            end
            DONE: begin
                digest_valid = 1'b1;
                nxt          = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Block capture, round counter and one-word-per-round schedule shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sched     <= '{default: 64'd0};
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            round_idx <= 7'd0;
        end else begin
            round_idx <= round_en ? round_idx + 7'd1 : 7'd0;
            if (state == IDLE && accept) begin
                for (int i = 0; i < 16; i++) sched[i] <= blk_data[1023-64*i -: 64];
                first_q <= blk_first;
                last_q  <= blk_last;
            end else if (round_en) begin
                for (int i = 0; i < 15; i++) sched[i] <= sched[i+1];
                sched[15] <= w_new;
            end
        end
    end

`ifdef SHA512_BLK_CNT_EN
    // Blocks hashed in the current message; restarts on a first block, saturates at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            blk_count <= '0;
        else if (load_wv && init_h)
            blk_count <= '0;
        else if (update_h && !(&blk_count))
            blk_count <= blk_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sha512_round_ctrl.sv
// tb_sha512_round_ctrl: table-driven bench with a behavioural SHA-512 datapath driven by the controller strobes.
// Checks blk_count as well when built with SHA512_BLK_CNT_EN.
module tb_sha512_round_ctrl;

    localparam logic [511:0] IV = 512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179;
    localparam logic [511:0] ABC_DIG = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef struct {
        logic [1023:0] data;
        logic          first;
        logic          last;
        int            exp_ready;
        logic [511:0]  exp_h;
        int            exp_cnt;
    } vec_t;

    localparam int NV = 9;

    logic          clk, reset_n, blk_valid, blk_ready, blk_first, blk_last;
    logic [1023:0] blk_data;
    logic          init_h, load_wv, round_en, update_h, digest_valid, busy;
    logic [6:0]    round_idx;
    logic [63:0]   w_t;
    logic [31:0]   blk_count;
    logic [511:0]  hm, wv;
    vec_t          vt [NV];
    int            tests, fails;
    int            n_init, n_upd, n_dv;

    sha512_round_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data(blk_data),
        .blk_first(blk_first),
        .blk_last(blk_last),
        .init_h(init_h),
        .load_wv(load_wv),
        .round_en(round_en),
        .round_idx(round_idx),
        .w_t(w_t),
        .update_h(update_h),
        .digest_valid(digest_valid),
`ifdef SHA512_BLK_CNT_EN
        .blk_count(blk_count),
`endif
        .busy(busy)
    );

`ifndef SHA512_BLK_CNT_EN
    assign blk_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] ss0(input logic [63:0] x);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ss1(input logic [63:0] x);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    function automatic logic [63:0] wt(input logic [1023:0] blk, input int t);
        logic [63:0] w [80];
        for (int i = 0; i < 80; i++)
            w[i] = i < 16 ? blk[1023-64*i -: 64] : ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
        return w[t];
    endfunction

    function automatic logic [511:0] rnd(input logic [511:0] s, input logic [63:0] k, input logic [63:0] w);
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [511:0] add8(input logic [511:0] x, input logic [511:0] y);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[511-64*i -: 64] = x[511-64*i -: 64] + y[511-64*i -: 64];
        return r;
    endfunction

    function automatic logic [511:0] compress(input logic [511:0] h, input logic [1023:0] blk);
        logic [511:0] s;
        s = h;
        for (int t = 0; t < 80; t++) s = rnd(s, K[t], wt(blk, t));
        return add8(h, s);
    endfunction

    // Behavioural round datapath: IV load takes priority over H when loading working vars
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hm <= '0;
            wv <= '0;
        end else begin
            if (init_h) hm <= IV;
            if (load_wv) wv <= init_h ? IV : hm;
            if (round_en) wv <= rnd(wv, K[round_idx], w_t);
            if (update_h) hm <= add8(hm, wv);
        end
    end

    // Strobe tallies used to spot lost or duplicated blocks
    always @(negedge clk) begin
        if (init_h) n_init++;
        if (update_h) n_upd++;
        if (digest_valid) n_dv++;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        logic [63:0] we [80];
        int n, rc, uc, dc;
        bit done;
        for (int t = 0; t < 80; t++) we[t] = wt(vt[v].data, t);
        n = 0;
        while (!blk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_handshake", blk_ready, 1'b1);
        @(posedge clk);
        #1;
        if (v < NV - 1) begin
            blk_data  = vt[v+1].data;
            blk_first = vt[v+1].first;
            blk_last  = vt[v+1].last;
        end else begin
            blk_valid = 1'b0;
        end
        rc = 0; uc = 0; dc = 0; done = 0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("load_wv_c1", load_wv, 1'b1);
                chk("init_h_c1", init_h, vt[v].first);
                chk("busy_c1", {busy, blk_ready}, 2'b10);
            end
            if (round_en) begin
                rc++;
                chk("round_idx", round_idx, c - 2);
                if (c >= 2 && c <= 81) chk("w_t", w_t, we[c-2]);
                if (v == 0 && c == 18) chk("abc_w16", w_t, 64'h6162638000000000);
                if (v == 0 && c == 19) chk("abc_w17", w_t, 64'h00030000000000C0);
            end
            if (update_h) begin
                uc++;
                chk("update_cycle", c, 82);
            end
            if (digest_valid) begin
                dc++;
                chk("digest_cycle", c, 83);
                chk("digest", hm, vt[v].exp_h);
            end
            if (blk_ready) begin
                done = 1;
                chk("ready_cycle", c, vt[v].exp_ready);
`ifdef SHA512_BLK_CNT_EN
                chk("blk_count", blk_count, vt[v].exp_cnt);
`endif
            end
        end
        chk("ready_timeout", done, 1'b1);
        chk("round_count", rc, 80);
        chk("update_count", uc, 1);
        chk("digest_count", dc, vt[v].last);
    endtask

    initial begin
        logic [1023:0] abc, p;
        logic [511:0]  ch;
        logic [1:0]    fl [NV];
        int            cnt, n, s_init, s_upd, s_dv, bad;
        tests = 0; fails = 0; n_init = 0; n_upd = 0; n_dv = 0;
        reset_n = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0; blk_last = 1'b0;

        abc = '0;
        abc[1023:960] = 64'h6162638000000000;
        abc[63:0] = 64'h18;
        fl = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        ch = '0;
        cnt = 0;
        for (int v = 0; v < NV; v++) begin
            for (int j = 0; j < 16; j++) p[1023-64*j -: 64] = 64'h9e3779b97f4a7c15 * 64'(v * 16 + j + 1);
            vt[v].data  = fl[v] == 2'b11 ? abc : p;
            vt[v].first = fl[v][1];
            vt[v].last  = fl[v][0];
            vt[v].exp_ready = vt[v].last ? 84 : 83;
            if (vt[v].first) ch = IV;
            ch = compress(ch, vt[v].data);
            vt[v].exp_h = fl[v] == 2'b11 ? ABC_DIG : ch;
            cnt = vt[v].first ? 1 : cnt + 1;
            vt[v].exp_cnt = cnt;
        end

        repeat (3) @(negedge clk);
        chk("rst_ready", blk_ready, 1'b1);
        chk("rst_strobes", {busy, init_h, load_wv, round_en, update_h, digest_valid}, 6'b0);
        chk("rst_round_idx", round_idx, 7'd0);
        chk("rst_w_t", w_t, 64'd0);
        reset_n = 1'b1;

        blk_data = abc; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 blk_valid = 1'b0;
        n = 0;
        while (!(round_en && round_idx == 7'd40) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_t40", {round_en, round_idx}, {1'b1, 7'd40});
        reset_n = 1'b0;
        #1;
        chk("midrst_async", {busy, blk_ready, round_en, round_idx, w_t}, {1'b0, 1'b1, 1'b0, 7'd0, 64'd0});
        @(posedge clk);
        #1;
        chk("midrst_edge", {init_h, load_wv, round_en, update_h, digest_valid, blk_ready}, 6'b000001);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (update_h || digest_valid || busy) bad++;
        end
        chk("midrst_no_digest", bad, 0);

        s_init = n_init; s_upd = n_upd; s_dv = n_dv;
        blk_data = vt[0].data; blk_first = vt[0].first; blk_last = vt[0].last; blk_valid = 1'b1;
        for (int v = 0; v < NV; v++) run_vec(v);
        repeat (5) @(negedge clk);
        chk("total_init_h", n_init - s_init, 6);
        chk("total_update_h", n_upd - s_upd, NV);
        chk("total_digest", n_dv - s_dv, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
